// File: rtl/uart_fifo_pkg.sv
// Shared helpers for the UART datapath FIFO.
package uart_fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// Parametrised UART FIFO: data+parity entries, occupancy, threshold and sticky error flags,
// synchronous flush and registered or first-word-fall-through read.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   WR_EN,
  input  logic [DATA_W-1:0]      WR_DATA,
  input  logic                   WR_PARITY,
  input  logic                   RD_EN,
  output logic [DATA_W-1:0]      RD_DATA,
  output logic                   RD_PARITY,
  output logic                   RD_VALID,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic                   ALMOST_FULL,
  output logic                   ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  typedef struct packed {
    logic              parity;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr, level;
  logic          empty, full, rd_acc, wr_acc;
  entry_t        wr_entry, head;

  // Wrap bit makes the difference exact across the full 0..DEPTH range.
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));

  // A flush cycle accepts nothing; a pop frees the slot for a write at FULL.
  assign rd_acc = RD_EN && !empty && !CLR;
  assign wr_acc = WR_EN && (!full || rd_acc) && !CLR;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (CLR) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (WR_EN && !wr_acc) OVERFLOW  <= 1'b1;
      if (RD_EN && empty)   UNDERFLOW <= 1'b1;
    end
  end

  assign wr_entry = '{parity: WR_PARITY, data: WR_DATA};

  uart_fifo_ram #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_ram (
    .CLK   (CLK),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  assign EMPTY        = empty;
  assign FULL         = full;
  assign LEVEL        = level;
  assign ALMOST_FULL  = (level >= PW'(AF_LEVEL));
  assign ALMOST_EMPTY = (level <= PW'(AE_LEVEL));

  generate
    if (FWFT) begin : g_fwft
      // Head is forced to zero while empty so unwritten storage never leaks out.
      assign RD_VALID  = !empty;
      assign RD_DATA   = empty ? '0 : head.data;
      assign RD_PARITY = empty ? 1'b0 : head.parity;
    end else begin : g_reg
      logic [1:0] vld_pipe;
      entry_t     rd_q;

      assign vld_pipe[0] = rd_acc;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          vld_pipe[1] <= 1'b0;
          rd_q        <= '0;
        end else if (CLR) begin
          vld_pipe[1] <= 1'b0;
        end else begin
          vld_pipe[1] <= vld_pipe[0];
          if (rd_acc) rd_q <= head;
        end
      end

      assign RD_VALID  = vld_pipe[1];
      assign RD_DATA   = rd_q.data;
      assign RD_PARITY = rd_q.parity;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: registered and FWFT instances share stimulus, checked against a queue model.
module tb_uart_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST, CLR, WR_EN, WR_PARITY, RD_EN;
  logic [DW-1:0] WR_DATA;

  logic [DW-1:0] d0_data, d1_data;
  logic          d0_par, d1_par, d0_vld, d1_vld;
  logic          EMPTY, FULL, AF, AE, OVF, UNF;
  logic          e1, f1, af1, ae1, ovf1, unf1;
  logic [4:0]    LEVEL, level1;

  always #5 CLK = ~CLK;

  uart_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_PARITY(WR_PARITY),
    .RD_EN(RD_EN), .RD_DATA(d0_data), .RD_PARITY(d0_par), .RD_VALID(d0_vld), .EMPTY(EMPTY),
    .FULL(FULL), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .LEVEL(LEVEL), .OVERFLOW(OVF), .UNDERFLOW(UNF));

  uart_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_PARITY(WR_PARITY),
    .RD_EN(RD_EN), .RD_DATA(d1_data), .RD_PARITY(d1_par), .RD_VALID(d1_vld), .EMPTY(e1),
    .FULL(f1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .LEVEL(level1), .OVERFLOW(ovf1), .UNDERFLOW(unf1));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of {parity,data} plus sticky flags and the last registered read.
  logic [8:0] q[$];
  bit         m_ovf, m_unf, m_rdv;
  logic [8:0] m_rd;

  typedef struct {
    bit         wr, rd, clr;
    logic [7:0] data;
    bit         par;
    int         exp_level;
    bit         exp_ovf, exp_unf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit wr, bit rd, bit clr, logic [7:0] data, bit par,
                              int lvl, bit ovf, bit unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.data = data; v.par = par;
    v.exp_level = lvl; v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_rdv = 0; m_rd = '0;
  endtask

  task automatic model_edge(input bit wr, input bit rd, input bit clr, input logic [8:0] ent);
    int sz;
    bit ra, wa;
    if (clr) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0;
      return;
    end
    sz = q.size();
    ra = rd && (sz > 0);
    wa = wr && ((sz < DEPTH) || ra);
    if (wr && !wa) m_ovf = 1;
    if (rd && sz == 0) m_unf = 1;
    m_rdv = ra;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(ent);
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, " level"}, LEVEL, sz);
    chk({tag, " empty"}, EMPTY, sz == 0);
    chk({tag, " full"}, FULL, sz == DEPTH);
    chk({tag, " almost_full"}, AF, sz >= DEPTH - 2);
    chk({tag, " almost_empty"}, AE, sz <= 2);
    chk({tag, " overflow"}, OVF, m_ovf);
    chk({tag, " underflow"}, UNF, m_unf);
    chk({tag, " reg rd_valid"}, d0_vld, m_rdv);
    chk({tag, " reg rd_word"}, {d0_par, d0_data}, m_rd);
    chk({tag, " fwft rd_valid"}, d1_vld, sz > 0);
    if (sz > 0) chk({tag, " fwft rd_word"}, {d1_par, d1_data}, q[0]);
    else        chk({tag, " fwft rd_word idle"}, {d1_par, d1_data}, 0);
  endtask

  task automatic step(input bit wr, input bit rd, input bit clr, input logic [7:0] data,
                      input bit par, input string tag);
    WR_EN = wr; RD_EN = rd; CLR = clr; WR_DATA = data; WR_PARITY = par;
    @(posedge CLK);
    model_edge(wr, rd, clr, {par, data});
    #1;
    check_all(tag);
  endtask

  initial begin
    RST = 1'b0; CLR = 0; WR_EN = 0; RD_EN = 0; WR_DATA = '0; WR_PARITY = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Fill to FULL, overflow, read+write at FULL, drain, then underflow with a same-cycle write.
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 0, 8'(i), i[0], i + 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'hAA, 0, 16, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h55, 1, 16, 1, 0));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 1, 0, 8'h00, 0, 15 - i, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h33, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].data, tbl[i].par, "vec");
      chk("vec exp_level", LEVEL, tbl[i].exp_level);
      chk("vec exp_overflow", OVF, tbl[i].exp_ovf);
      chk("vec exp_underflow", UNF, tbl[i].exp_unf);
    end

    // Continuous read+write at LEVEL=3 across several pointer wraps.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'($urandom), 1'($urandom), "wrap fill");
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 8'($urandom), 1'($urandom), "wrap");
      chk("wrap level3", LEVEL, 3);
    end
    step(0, 0, 1, 8'h00, 0, "wrap clr");

    // FWFT head presented without a read request.
    step(1, 0, 0, 8'h7E, 0, "fwft wr");
    chk("fwft 7E valid", d1_vld, 1);
    chk("fwft 7E data", d1_data, 8'h7E);
    step(0, 1, 0, 8'h00, 0, "fwft rd");
    chk("fwft pop empty", EMPTY, 1);

    // LEVEL=5 with OVERFLOW set, then CLR beats a concurrent write.
    for (int i = 0; i < 17; i++) step(1, 0, 0, 8'(8'h40 + i), 0, "lvl5 fill");
    for (int i = 0; i < 11; i++) step(0, 1, 0, 8'h00, 0, "lvl5 drain");
    chk("lvl5 level", LEVEL, 5);
    chk("lvl5 overflow", OVF, 1);
    step(1, 0, 1, 8'hEE, 1, "clr+wr");
    chk("clr level", LEVEL, 0);
    chk("clr overflow", OVF, 0);

    // Randomised traffic with write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 99) < 2, 8'($urandom), 1'($urandom), "rand");
    end

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 6; i++) step(1, i > 2, 0, 8'(8'h90 + i), 1, "burst");
    WR_EN = 1; RD_EN = 1; WR_DATA = 8'hC3; WR_PARITY = 1; CLR = 0;
    @(posedge CLK);
    model_edge(1, 1, 0, {1'b1, 8'hC3});
    #3;
    RST = 1'b0;
    #1;
    model_reset();
    check_all("async rst");
    chk("async rst reg data", d0_data, 0);
    @(negedge CLK);
    RST = 1'b1;
    step(0, 1, 0, 8'h00, 0, "post rst rd");
    step(1, 0, 0, 8'h5A, 1, "post rst wr");
    step(0, 1, 0, 8'h00, 0, "post rst rd2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
